// File: rtl/id_hazard_scoreboard_if.sv
// ID-stage hazard scoreboard bus: decode-side request fields, flush/freeze
// controls, and the stall/status outputs returned to decode.
interface id_hazard_scoreboard_if #(
    parameter int STAGES = 2
);
    localparam int CNT_W = $clog2(STAGES + 1);

    logic             id_valid;
    logic             id_wb_en;
    logic [3:0]       id_dest;
    logic [3:0]       id_rn;
    logic             id_uses_rn;
    logic [3:0]       id_src2;
    logic             id_two_src;
    logic             flush;
    logic             freeze;
    logic             hazard;
    logic [15:0]      busy_mask;
    logic [CNT_W-1:0] pending_count;

    modport master (
        output id_valid, id_wb_en, id_dest, id_rn, id_uses_rn, id_src2, id_two_src,
        output flush, freeze,
        input  hazard, busy_mask, pending_count
    );

    modport slave (
        input  id_valid, id_wb_en, id_dest, id_rn, id_uses_rn, id_src2, id_two_src,
        input  flush, freeze,
        output hazard, busy_mask, pending_count
    );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Tracks destination registers of instructions between ID and writeback and
// stalls ID on read-after-write conflicts. slot[0] is EXE (youngest).
module id_hazard_scoreboard #(
    parameter int STAGES      = 2,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    id_hazard_scoreboard_if.slave bus
);
    localparam int CNT_W = $clog2(STAGES + 1);

    logic [STAGES-1:0]      r_vld;
    logic [STAGES-1:0][3:0] r_dest;

    logic [15:0]      w_busy;
    logic             w_hazard;
    logic             w_rec;
    logic [CNT_W-1:0] w_cnt;

    // Per-register pending-write flags; R15 is never tracked so bit 15 stays 0,
    // which also makes PC reads hazard-free.
    always_comb begin
        w_busy = '0;
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < STAGES; i++) begin
                if (r_vld[i] && (r_dest[i] == 4'(r))) w_busy[r] = 1'b1;
            end
        end
    end

    // Stall when a live source register has a pending write; a hazarded
    // instruction is not recorded so ID can re-present it.
    always_comb begin
        w_hazard = bus.id_valid &
                   ((bus.id_uses_rn & w_busy[bus.id_rn]) |
                    (bus.id_two_src & w_busy[bus.id_src2]));
        w_rec    = bus.id_valid & bus.id_wb_en & ~w_hazard & (bus.id_dest != 4'hF);
    end

    // Popcount of valid slots.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < STAGES; i++) w_cnt = w_cnt + CNT_W'(r_vld[i]);
    end

    // Slot shift register: hold on freeze, shift otherwise; flush kills the
    // youngest FLUSH_DEPTH slots after the shift and blocks recording.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_dest <= '0;
        end else if (!bus.freeze) begin
            r_vld[0]  <= w_rec & ~bus.flush;
            r_dest[0] <= bus.id_dest;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i]  <= r_vld[i-1] & ~(bus.flush & (i < FLUSH_DEPTH));
                r_dest[i] <= r_dest[i-1];
            end
        end
    end

    assign bus.hazard        = w_hazard;
    assign bus.busy_mask     = w_busy;
    assign bus.pending_count = w_cnt;
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Scoreboard bench: driver pushes expected outputs from an age-list model,
// a negedge monitor pops and compares against the DUT.
module tb_id_hazard_scoreboard;
    localparam int STAGES = 2;
    localparam int FD     = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_hazard_scoreboard_if #(.STAGES(STAGES)) bus();
    id_hazard_scoreboard #(.STAGES(STAGES), .FLUSH_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic        hz;
        logic [15:0] bm;
        int          cnt;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Model: each in-flight write is a (dest, age) record; age counts
    // pipeline advances since entering EXE and it retires at age STAGES.
    int         m_age[$];
    logic [3:0] m_dest[$];

    function automatic logic m_busy(input logic [3:0] r);
        if (r == 4'hF) return 1'b0;
        foreach (m_dest[k]) if (m_dest[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_hz();
        return bus.id_valid && ((bus.id_uses_rn && m_busy(bus.id_rn)) ||
                                (bus.id_two_src && m_busy(bus.id_src2)));
    endfunction

    function automatic logic [15:0] m_mask();
        logic [15:0] bm = '0;
        for (int r = 0; r < 16; r++) bm[r] = m_busy(4'(r));
        return bm;
    endfunction

    task automatic model_edge();
        int         na[$];
        logic [3:0] nd[$];
        logic       hz;
        logic       rec;
        hz  = m_hz();
        rec = bus.id_valid && bus.id_wb_en && !hz && (bus.id_dest != 4'hF);
        if (rst) begin
            m_age.delete();
            m_dest.delete();
        end else if (!bus.freeze) begin
            foreach (m_age[k]) begin
                if ((m_age[k] + 1 < STAGES) && !(bus.flush && (m_age[k] + 1 < FD))) begin
                    na.push_back(m_age[k] + 1);
                    nd.push_back(m_dest[k]);
                end
            end
            if (rec && !bus.flush) begin
                na.push_back(0);
                nd.push_back(bus.id_dest);
            end
            m_age  = na;
            m_dest = nd;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One cycle: advance the model on the edge, apply new inputs, queue expectation.
    task automatic drive(input logic v, input logic wb, input logic [3:0] d,
                         input logic [3:0] rn, input logic urn,
                         input logic [3:0] s2, input logic ts,
                         input logic fl, input logic fz, input logic rs,
                         input string tag);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        bus.id_valid = v;  bus.id_wb_en = wb; bus.id_dest = d;
        bus.id_rn = rn;    bus.id_uses_rn = urn;
        bus.id_src2 = s2;  bus.id_two_src = ts;
        bus.flush = fl;    bus.freeze = fz;   rst = rs;
        e.hz  = m_hz();
        e.bm  = m_mask();
        e.cnt = m_age.size();
        e.tag = tag;
        q.push_back(e);
        #1;
    endtask

    task automatic idle(input string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    // Monitor: outputs are always presented, compare every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".hazard"}, int'(bus.hazard), int'(e.hz));
                chk({e.tag, ".busy"},   int'(bus.busy_mask), int'(e.bm));
                chk({e.tag, ".count"},  int'(bus.pending_count), e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.id_valid = 0; bus.id_wb_en = 0; bus.id_dest = 0; bus.id_rn = 0;
        bus.id_uses_rn = 0; bus.id_src2 = 0; bus.id_two_src = 0;
        bus.flush = 0; bus.freeze = 0;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rst");
        idle("rst_rel");
        chk("reset.hazard", int'(bus.hazard), 0);
        chk("reset.busy", int'(bus.busy_mask), 0);
        chk("reset.count", int'(bus.pending_count), 0);

        // Back-to-back RAW
        drive(1, 1, 4'd1, 0, 0, 0, 0, 0, 0, 0, "raw.add");
        drive(1, 1, 4'd2, 4'd1, 1, 0, 0, 0, 0, 0, "raw.sub0");
        chk("raw.c1.hazard", int'(bus.hazard), 1);
        chk("raw.c1.busy", int'(bus.busy_mask), 16'h0002);
        drive(1, 1, 4'd2, 4'd1, 1, 0, 0, 0, 0, 0, "raw.sub1");
        chk("raw.c2.hazard", int'(bus.hazard), 1);
        chk("raw.c2.busy", int'(bus.busy_mask), 16'h0002);
        drive(1, 1, 4'd2, 4'd1, 1, 0, 0, 0, 0, 0, "raw.sub2");
        chk("raw.c3.hazard", int'(bus.hazard), 0);
        idle("raw.i0"); idle("raw.i1"); idle("raw.i2");

        // Source gating
        drive(1, 1, 4'd3, 0, 0, 0, 0, 0, 0, 0, "gate.rec");
        drive(1, 0, 4'd0, 4'd3, 0, 4'd3, 0, 0, 0, 0, "gate.off");
        chk("gate.off.hazard", int'(bus.hazard), 0);
        drive(1, 0, 4'd0, 4'd0, 0, 4'd3, 1, 0, 0, 0, "gate.on");
        chk("gate.two_src.hazard", int'(bus.hazard), 1);
        idle("gate.i0"); idle("gate.i1");

        // R15
        drive(1, 1, 4'hF, 0, 0, 0, 0, 0, 0, 0, "r15.wr");
        drive(1, 0, 4'd0, 4'hF, 1, 4'hF, 1, 0, 0, 0, "r15.rd");
        chk("r15.busy", int'(bus.busy_mask), 0);
        chk("r15.count", int'(bus.pending_count), 0);
        chk("r15.hazard", int'(bus.hazard), 0);
        idle("r15.i0");

        // Flush
        drive(1, 1, 4'd4, 0, 0, 0, 0, 0, 0, 0, "fl.rec");
        drive(1, 1, 4'd5, 0, 0, 0, 0, 1, 0, 0, "fl.flush");
        chk("flush.c1.busy", int'(bus.busy_mask), 16'h0010);
        idle("fl.i0");
        chk("flush.c2.busy", int'(bus.busy_mask), 16'h0010);
        chk("flush.c2.count", int'(bus.pending_count), 1);
        idle("fl.i1");
        chk("flush.c3.busy", int'(bus.busy_mask), 0);
        idle("fl.i2");

        // Freeze
        drive(1, 1, 4'd2, 0, 0, 0, 0, 0, 0, 0, "fz.rec");
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 4'd8, 4'd2, 1, 0, 0, 0, 1, 0, "fz.hold");
            chk("freeze.hazard", int'(bus.hazard), 1);
            chk("freeze.busy", int'(bus.busy_mask), 16'h0004);
        end
        drive(1, 1, 4'd8, 4'd2, 1, 0, 0, 0, 0, 0, "fz.r0");
        drive(1, 1, 4'd8, 4'd2, 1, 0, 0, 0, 0, 0, "fz.r1");
        chk("freeze.rel2.hazard", int'(bus.hazard), 1);
        drive(1, 1, 4'd8, 4'd2, 1, 0, 0, 0, 0, 0, "fz.r2");
        chk("freeze.rel3.hazard", int'(bus.hazard), 0);
        idle("fz.i0"); idle("fz.i1"); idle("fz.i2");

        // Reset mid-flight
        drive(1, 1, 4'd6, 0, 0, 0, 0, 0, 0, 0, "mr.r6");
        drive(1, 1, 4'd7, 0, 0, 0, 0, 0, 0, 0, "mr.r7");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "mr.rst");
        chk("midrst.pre.count", int'(bus.pending_count), 2);
        drive(1, 0, 4'd0, 4'd6, 1, 0, 0, 0, 0, 0, "mr.dep");
        chk("midrst.hazard", int'(bus.hazard), 0);
        chk("midrst.busy", int'(bus.busy_mask), 0);
        chk("midrst.count", int'(bus.pending_count), 0);

        // Randomized traffic over a small register window to force conflicts
        for (int n = 0; n < 600; n++) begin
            logic [3:0] d, rn, s2;
            d  = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            rn = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            s2 = 4'($urandom_range(0, 7));
            drive(($urandom_range(0, 4) != 0), $urandom_range(0, 1), d, rn,
                  $urandom_range(0, 1), s2, $urandom_range(0, 1),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 49) == 0), "rnd");
        end

        idle("end");
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
